// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_write_arbiter
//  Function : round-robin arbiter sharing the register-file write port, with a
//             one-entry registered output stage and a pending-write bitmap.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_write_arbiter #(
  parameter int width     = 32,
  parameter int addrWidth = 5,
  parameter int depth     = 32,
  parameter int NREQ      = 2
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic                      Freeze,
  input  logic [NREQ-1:0]           ReqValid,
  input  logic [NREQ*addrWidth-1:0] ReqAddr,
  input  logic [NREQ*width-1:0]     ReqData,
  output logic [NREQ-1:0]           ReqReady,
  output logic                      RegWrite,
  output logic [addrWidth-1:0]      WriteRegister,
  output logic [width-1:0]          WriteData,
  output logic [depth-1:0]          Pending,
  output logic                      Dropped
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic                 regwrite_q, regwrite_d;
  logic [addrWidth-1:0] wreg_q, wreg_d;
  logic [width-1:0]     wdata_q, wdata_d;
  logic                 dropped_q, dropped_d;

  logic                 grant_any;
  logic [PTR_W-1:0]     grant_idx;
  logic [PTR_W:0]       scan;
  logic [addrWidth-1:0] sel_addr;
  logic [width-1:0]     sel_data;

  // Scan from the farthest candidate back to ptr so the nearest valid one wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan      = '0;
    if (!Freeze) begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        scan = {1'b0, ptr_q} + (PTR_W+1)'(k);
        if (scan >= (PTR_W+1)'(NREQ)) scan = scan - (PTR_W+1)'(NREQ);
        if (ReqValid[scan[PTR_W-1:0]]) begin
          grant_any = 1'b1;
          grant_idx = scan[PTR_W-1:0];
        end
      end
    end
  end

  generate
    for (genvar i = 0; i < NREQ; i++) begin : g_ready
      assign ReqReady[i] = grant_any && (grant_idx == PTR_W'(i));
    end
  endgenerate

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == PTR_W'(i)) begin
        sel_addr = ReqAddr[i*addrWidth +: addrWidth];
        sel_data = ReqData[i*width +: width];
      end
    end
  end

  always_comb begin
    ptr_d      = ptr_q;
    regwrite_d = 1'b0;
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;
    dropped_d  = 1'b0;
    if (grant_any) begin
      ptr_d = (grant_idx == PTR_W'(NREQ - 1)) ? '0 : grant_idx + PTR_W'(1);
      // Writes to r0 are swallowed here so the regfile never sees them.
      if (sel_addr != '0) begin
        regwrite_d = 1'b1;
        wreg_d     = sel_addr;
        wdata_d    = sel_data;
      end else begin
        dropped_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ptr_q      <= '0;
      regwrite_q <= 1'b0;
      wreg_q     <= '0;
      wdata_q    <= '0;
      dropped_q  <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      regwrite_q <= regwrite_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
      dropped_q  <= dropped_d;
    end
  end

  assign RegWrite      = regwrite_q;
  assign WriteRegister = wreg_q;
  assign WriteData     = wdata_q;
  assign Dropped       = dropped_q;
  assign Pending       = regwrite_q ? (depth'(1) << wreg_q) : '0;

endmodule
`default_nettype wire
